sreg_responder: RTL and testbench



---
 rtl/sreg_responder_if.sv | 24 ++
 rtl/sreg_responder.sv | 128 ++++++++++++
 tb/tb_sreg_responder.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/sreg_responder_if.sv
// rtl/sreg_responder_if.sv - serial shift-register link between sreg_ctrl and the pixel-side responder.
interface sreg_responder_if;
  logic       sclk;
  logic       shift;
  logic       serial_in;
  logic       write_cfg;
  logic [1:0] sreg_out;

  modport master (
    output sclk,
    output shift,
    output serial_in,
    output write_cfg,
    input  sreg_out
  );

  modport slave (
    input  sclk,
    input  shift,
    input  serial_in,
    input  write_cfg,
    output sreg_out
  );
endinterface

// File: rtl/sreg_responder.sv
// rtl/sreg_responder.sv - oversampling pixel-side shift register with config latch.
module sreg_responder #(
  parameter int WIDTH       = 42,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  sreg_responder_if.slave   link,
  input  logic [WIDTH-1:0]  pixel_in,
  output logic [WIDTH-1:0]  cfg_out,
  output logic              cfg_valid,
  output logic [5:0]        shift_count,
  output logic              overflow
);

  localparam logic [5:0] WIDTH_C = 6'(WIDTH);
  localparam int         HALF    = WIDTH / 2;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_SHIFT,
    OP_LOAD
  } op_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] shift_sync_q, shift_sync_d;
  logic [SYNC_STAGES-1:0] serial_sync_q, serial_sync_d;
  logic [SYNC_STAGES-1:0] cfg_sync_q, cfg_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cfg_prev_q, cfg_prev_d;

  logic [WIDTH-1:0]       sr_q, sr_d;
  logic [WIDTH-1:0]       cfg_out_q, cfg_out_d;
  logic                   cfg_valid_q, cfg_valid_d;
  logic [1:0]             sreg_out_q, sreg_out_d;
  logic [5:0]             shift_count_q, shift_count_d;
  logic                   overflow_q, overflow_d;

  logic sclk_s, shift_s, serial_s, cfg_s;
  logic sclk_rise, cfg_rise;
  op_e  op;

  // All four link inputs share one depth so shift/serial_in line up with their sclk edge.
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign shift_s   = shift_sync_q[SYNC_STAGES-1];
  assign serial_s  = serial_sync_q[SYNC_STAGES-1];
  assign cfg_s     = cfg_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign cfg_rise  = cfg_s & ~cfg_prev_q;

  always_comb begin
    op = OP_IDLE;
    if (sclk_rise) begin
      op = shift_s ? OP_SHIFT : OP_LOAD;
    end
  end

  always_comb begin
    sclk_sync_d   = {sclk_sync_q[SYNC_STAGES-2:0], link.sclk};
    shift_sync_d  = {shift_sync_q[SYNC_STAGES-2:0], link.shift};
    serial_sync_d = {serial_sync_q[SYNC_STAGES-2:0], link.serial_in};
    cfg_sync_d    = {cfg_sync_q[SYNC_STAGES-2:0], link.write_cfg};
    sclk_prev_d   = sclk_s;
    cfg_prev_d    = cfg_s;

    sr_d          = sr_q;
    shift_count_d = shift_count_q;
    overflow_d    = overflow_q;
    unique case (op)
      OP_SHIFT: begin
        sr_d = {sr_q[WIDTH-2:0], serial_s};
        if (shift_count_q < WIDTH_C) begin
          shift_count_d = shift_count_q + 6'd1;
        end else begin
          overflow_d = 1'b1;
        end
      end
      OP_LOAD: begin
        sr_d          = pixel_in;
        shift_count_d = 6'd0;
        overflow_d    = 1'b0;
      end
      default: ;
    endcase

    sreg_out_d  = {sr_q[WIDTH-1], sr_q[HALF-1]};
    // Reads sr_q, so a config edge coinciding with a shift captures the pre-shift word.
    cfg_out_d   = cfg_rise ? sr_q : cfg_out_q;
    cfg_valid_d = cfg_rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q   <= '1;
      sclk_prev_q   <= 1'b1;
      shift_sync_q  <= '0;
      serial_sync_q <= '0;
      cfg_sync_q    <= '0;
      cfg_prev_q    <= 1'b0;
      sr_q          <= '0;
      cfg_out_q     <= '0;
      cfg_valid_q   <= 1'b0;
      sreg_out_q    <= 2'b00;
      shift_count_q <= 6'd0;
      overflow_q    <= 1'b0;
    end else begin
      sclk_sync_q   <= sclk_sync_d;
      sclk_prev_q   <= sclk_prev_d;
      shift_sync_q  <= shift_sync_d;
      serial_sync_q <= serial_sync_d;
      cfg_sync_q    <= cfg_sync_d;
      cfg_prev_q    <= cfg_prev_d;
      sr_q          <= sr_d;
      cfg_out_q     <= cfg_out_d;
      cfg_valid_q   <= cfg_valid_d;
      sreg_out_q    <= sreg_out_d;
      shift_count_q <= shift_count_d;
      overflow_q    <= overflow_d;
    end
  end

  assign link.sreg_out = sreg_out_q;
  assign cfg_out       = cfg_out_q;
  assign cfg_valid     = cfg_valid_q;
  assign shift_count   = shift_count_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_sreg_responder.sv
// tb/tb_sreg_responder.sv - directed scoreboard bench for sreg_responder.
module tb_sreg_responder;
  localparam int W = 42;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] pixel_in;
  logic [W-1:0] cfg_out;
  logic         cfg_valid;
  logic [5:0]   shift_count;
  logic         overflow;

  sreg_responder_if link ();

  sreg_responder #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .link        (link),
    .pixel_in    (pixel_in),
    .cfg_out     (cfg_out),
    .cfg_valid   (cfg_valid),
    .shift_count (shift_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int cfg_pulses;
  always @(posedge clk) begin
    if (cfg_valid === 1'b1) cfg_pulses <= cfg_pulses + 1;
  end

  typedef enum int {K_SREG, K_CNT, K_OVF, K_CFG, K_NCFG} kind_e;
  typedef struct {
    kind_e       kind;
    logic [63:0] val;
    string       tag;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  int           cfg_base;
  logic [W-1:0] m_sr;
  logic [5:0]   m_cnt;
  logic         m_ovf;
  logic [W-1:0] word;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] observe(input kind_e k);
    case (k)
      K_SREG:  return 64'(link.sreg_out);
      K_CNT:   return 64'(shift_count);
      K_OVF:   return 64'(overflow);
      K_CFG:   return 64'(cfg_out);
      default: return 64'(cfg_pulses - cfg_base);
    endcase
  endfunction

  task automatic push(input kind_e k, input string tag, input logic [63:0] v);
    exp_t e;
    e.kind = k;
    e.val  = v;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.kind), e.val);
    end
  endtask

  task automatic model_edge(input logic sh, input logic b);
    if (sh) begin
      m_sr = {m_sr[W-2:0], b};
      if (m_cnt < 6'(W)) m_cnt = m_cnt + 6'd1;
      else m_ovf = 1'b1;
    end else begin
      m_sr  = pixel_in;
      m_cnt = 6'd0;
      m_ovf = 1'b0;
    end
  endtask

  // One full sclk period: low phase carries shift/serial_in, checks land 4 clks after the rise.
  task automatic sclk_pulse(input logic sh, input logic b, input string tag);
    @(negedge clk);
    link.shift     = sh;
    link.serial_in = b;
    link.sclk      = 1'b0;
    repeat (3) @(negedge clk);
    link.sclk = 1'b1;
    cfg_base  = cfg_pulses;
    model_edge(sh, b);
    push(K_SREG, {tag, "_sreg_out"}, 64'({m_sr[W-1], m_sr[W/2-1]}));
    push(K_CNT,  {tag, "_shift_count"}, 64'(m_cnt));
    push(K_OVF,  {tag, "_overflow"}, 64'(m_ovf));
    push(K_NCFG, {tag, "_no_cfg_valid"}, 64'd0);
    repeat (4) @(negedge clk);
    drain();
  endtask

  task automatic cfg_pulse(input string tag);
    @(negedge clk);
    cfg_base       = cfg_pulses;
    link.write_cfg = 1'b1;
    push(K_CFG,  {tag, "_cfg_out"}, 64'(m_sr));
    push(K_NCFG, {tag, "_cfg_valid_count"}, 64'd1);
    repeat (7) @(negedge clk);
    drain();
    link.write_cfg = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sreg_out"}, 64'(link.sreg_out), 64'd0);
    check({tag, "_cfg_out"}, 64'(cfg_out), 64'd0);
    check({tag, "_cfg_valid"}, 64'(cfg_valid), 64'd0);
    check({tag, "_shift_count"}, 64'(shift_count), 64'd0);
    check({tag, "_overflow"}, 64'(overflow), 64'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    link.sclk      = 1'b1;
    link.shift     = 1'b0;
    link.serial_in = 1'b0;
    link.write_cfg = 1'b0;
    pixel_in       = '0;
    m_sr  = '0;
    m_cnt = 6'd0;
    m_ovf = 1'b0;

    // Reset with sclk idle high, then 10 quiet cycles.
    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    cfg_base = cfg_pulses;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_reset_outputs("after_release");
    check("after_release_no_cfg_pulse", 64'(cfg_pulses - cfg_base), 64'd0);

    // Full 42-bit write, MSB first, then latch config.
    word = 42'h26B4B5F692B;
    for (int i = W - 1; i >= 0; i--) sclk_pulse(1'b1, word[i], "write");
    check("write_model_word", 64'(m_sr), 64'(42'h26B4B5F692B));
    cfg_pulse("write_cfg");

    // Parallel load then 21 read shifts, two bits per sclk.
    pixel_in = 42'h3FF_0000_0001;
    sclk_pulse(1'b0, 1'b0, "load");
    check("load_sreg_out_first", 64'(link.sreg_out), 64'(2'b10));
    for (int i = 1; i <= W / 2; i++) begin
      sclk_pulse(1'b1, 1'b0, "read");
      if (i == 20) check("read_lane0_low_bit_at_20", 64'(link.sreg_out[0]), 64'd1);
    end

    // 43 shifts after a load saturate the counter and set overflow; a load clears it.
    pixel_in = 42'h0;
    sclk_pulse(1'b0, 1'b0, "ovf_load");
    for (int i = 0; i < W + 1; i++) sclk_pulse(1'b1, 1'(i % 3 == 0), "ovf_shift");
    check("ovf_set", 64'(overflow), 64'd1);
    check("ovf_count_sat", 64'(shift_count), 64'd42);
    sclk_pulse(1'b0, 1'b0, "ovf_clear_load");

    // write_cfg and sclk rise in the same clk cycle with sr = 1.
    pixel_in = 42'h1;
    sclk_pulse(1'b0, 1'b0, "sim_load");
    @(negedge clk);
    link.shift     = 1'b1;
    link.serial_in = 1'b0;
    link.sclk      = 1'b0;
    repeat (3) @(negedge clk);
    cfg_base       = cfg_pulses;
    link.sclk      = 1'b1;
    link.write_cfg = 1'b1;
    push(K_CFG,  "sim_cfg_pre_update", 64'(m_sr));
    model_edge(1'b1, 1'b0);
    push(K_NCFG, "sim_cfg_valid_count", 64'd1);
    push(K_CNT,  "sim_shift_count", 64'(m_cnt));
    repeat (5) @(negedge clk);
    drain();
    link.write_cfg = 1'b0;
    repeat (3) @(negedge clk);
    cfg_pulse("sim_sr_after");
    check("sim_sr_is_2", 64'(cfg_out), 64'(42'h2));

    // Asynchronous reset after 17 shifts, then a fresh write.
    pixel_in = '1;
    sclk_pulse(1'b0, 1'b0, "mid_load");
    for (int i = 0; i < 17; i++) sclk_pulse(1'b1, 1'b1, "mid_shift");
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    m_sr  = '0;
    m_cnt = 6'd0;
    m_ovf = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    cfg_pulse("post_reset_sr");
    word = 42'h2A5_C3C3_1234;
    for (int i = W - 1; i >= 0; i--) sclk_pulse(1'b1, word[i], "rewrite");
    cfg_pulse("rewrite_cfg");
    check("rewrite_cfg_value", 64'(cfg_out), 64'(42'h2A5_C3C3_1234));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
